// File: rtl/aes_key_expander_if.sv
// rtl/aes_key_expander_if.sv - start/key request and round key memory write port of the key expander
interface aes_key_expander_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [DATA_WIDTH-1:0] key_in;
  logic                  busy;
  logic                  done;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  modport master (
    output start, key_in,
    input  busy, done, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  start, key_in,
    output busy, done, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128 key schedule, one round key written to memory per clock
module aes_key_expander #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 11,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  aes_key_expander_if.slave bus
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_EXPAND = 1'b1;
  localparam logic [3:0] LAST_ROUND = 4'(DEPTH - 1);

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  logic [0:0]            state;
  logic [3:0]            round;
  logic [DATA_WIDTH-1:0] rk;
  logic [DATA_WIDTH-1:0] rk_next;
  logic [7:0]            rcon;
  logic [31:0]           rot_w3;
  logic [31:0]           sub_w3;
  logic [31:0]           t_word;
  logic [31:0]           w0_n;
  logic [31:0]           w1_n;
  logic [31:0]           w2_n;
  logic [31:0]           w3_n;

  // rcon for the key being produced, i.e. index round+1
  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    rot_w3  = {rk[23:0], rk[31:24]};
    sub_w3  = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
               sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
    t_word  = sub_w3 ^ {rcon, 24'h000000};
    w0_n    = rk[127:96] ^ t_word;
    w1_n    = rk[95:64]  ^ w0_n;
    w2_n    = rk[63:32]  ^ w1_n;
    w3_n    = rk[31:0]   ^ w2_n;
    rk_next = {w0_n, w1_n, w2_n, w3_n};
  end

  // Outputs are loaded with the values of the write they describe, so the
  // memory sees addr/din/we aligned in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      round        <= 4'd0;
      rk           <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state        <= S_EXPAND;
            round        <= 4'd0;
            rk           <= bus.key_in;
            bus.busy     <= 1'b1;
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= '0;
            bus.mem_din  <= bus.key_in;
          end
        end
        S_EXPAND: begin
          if (round < LAST_ROUND) begin
            round        <= round + 4'd1;
            rk           <= rk_next;
            bus.mem_addr <= ADDR_WIDTH'(round + 4'd1);
            bus.mem_din  <= rk_next;
          end else begin
            state        <= S_IDLE;
            round        <= 4'd0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed bench for aes_key_expander with an independent key schedule model
module tb_aes_key_expander;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] K3     = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expander_if #(.DATA_WIDTH(128), .ADDR_WIDTH(4)) bus ();

  aes_key_expander #(.DATA_WIDTH(128), .DEPTH(11), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  int           nwr;
  int           ndone;
  logic [3:0]   wr_addr   [0:63];
  logic [127:0] wr_data   [0:63];
  int           wr_edge   [0:63];
  int           done_edge [0:7];
  logic [127:0] ref_rk    [0:21];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic build_ref(input logic [127:0] key, input int base);
    logic [127:0] k  = key;
    logic [7:0]   rc = 8'h01;
    logic [31:0]  w [0:3];
    logic [31:0]  t;
    ref_rk[base] = k;
    for (int r = 1; r <= 10; r++) begin
      w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
      t = {sbox_ref(w[3][23:16]) ^ rc, sbox_ref(w[3][15:8]),
           sbox_ref(w[3][7:0]), sbox_ref(w[3][31:24])};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      k = {w[0], w[1], w[2], w[3]};
      ref_rk[base + r] = k;
      rc = gmul(rc, 8'h02);
    end
  endtask

  // mode 0: start pulse; 1: start held; 2: key_in scrambled after capture;
  // 3: second start with kb in the done cycle
  task automatic run_sched(input logic [127:0] ka, input logic [127:0] kb,
                           input int mode, input int n_edges);
    for (int i = 0; i < 64; i++) begin
      wr_addr[i] = 'x;
      wr_data[i] = 'x;
      wr_edge[i] = -1;
    end
    for (int i = 0; i < 8; i++) done_edge[i] = -1;
    nwr   = 0;
    ndone = 0;
    bus.key_in = ka;
    bus.start  = 1'b1;
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      #1;
      if (bus.mem_we === 1'b1 && nwr < 64) begin
        wr_addr[nwr] = bus.mem_addr;
        wr_data[nwr] = bus.mem_din;
        wr_edge[nwr] = e;
        nwr++;
      end
      if (bus.done === 1'b1 && ndone < 8) begin
        done_edge[ndone] = e;
        ndone++;
      end
      case (mode)
        1: bus.start = 1'b1;
        2: begin
          bus.start  = 1'b0;
          bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        3: begin
          if (bus.done === 1'b1 && ndone == 1) begin
            bus.start  = 1'b1;
            bus.key_in = kb;
          end else begin
            bus.start = 1'b0;
          end
        end
        default: bus.start = 1'b0;
      endcase
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.key_in = '0;
    rst = 1'b1;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr); end
    checks++; if (bus.mem_din !== 128'h0) begin errors++; $display("FAIL reset_din: got %h expected 0", bus.mem_din); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_key();
    build_ref(K1, 0);
    run_sched(K1, K1, 0, 14);
    checks++; if (nwr !== 11) begin errors++; $display("FAIL known_nwr: got %0d expected 11", nwr); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL known_ndone: got %0d expected 1", ndone); end
    checks++; if (done_edge[0] !== 12) begin errors++; $display("FAIL known_done_edge: got %0d expected 12", done_edge[0]); end
    checks++; if (wr_data[0] !== K1) begin errors++; $display("FAIL known_addr0: got %h expected %h", wr_data[0], K1); end
    checks++; if (wr_data[1] !== K1_R1) begin errors++; $display("FAIL known_addr1: got %h expected %h", wr_data[1], K1_R1); end
    checks++; if (wr_data[10] !== K1_R10) begin errors++; $display("FAIL known_addr10: got %h expected %h", wr_data[10], K1_R10); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (wr_addr[i] !== 4'(i)) begin errors++; $display("FAIL known_seq_addr[%0d]: got %0d expected %0d", i, wr_addr[i], i); end
      checks++; if (wr_edge[i] !== i + 1) begin errors++; $display("FAIL known_seq_edge[%0d]: got %0d expected %0d", i, wr_edge[i], i + 1); end
      checks++; if (wr_data[i] !== ref_rk[i]) begin errors++; $display("FAIL known_rk[%0d]: got %h expected %h", i, wr_data[i], ref_rk[i]); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL known_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_zero_key();
    run_sched(128'h0, 128'h0, 0, 14);
    checks++; if (nwr !== 11) begin errors++; $display("FAIL zero_nwr: got %0d expected 11", nwr); end
    checks++; if (wr_data[0] !== 128'h0) begin errors++; $display("FAIL zero_addr0: got %h expected 0", wr_data[0]); end
    checks++; if (wr_data[1] !== KZ_R1) begin errors++; $display("FAIL zero_addr1: got %h expected %h", wr_data[1], KZ_R1); end
    checks++; if (wr_data[10] !== KZ_R10) begin errors++; $display("FAIL zero_addr10: got %h expected %h", wr_data[10], KZ_R10); end
    checks++; if (wr_addr[10] !== 4'd10) begin errors++; $display("FAIL zero_last_addr: got %0d expected 10", wr_addr[10]); end
  endtask

  task automatic test_key_change();
    build_ref(K1, 0);
    run_sched(K1, K1, 2, 14);
    checks++; if (nwr !== 11) begin errors++; $display("FAIL keychg_nwr: got %0d expected 11", nwr); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (wr_data[i] !== ref_rk[i]) begin errors++; $display("FAIL keychg_rk[%0d]: got %h expected %h", i, wr_data[i], ref_rk[i]); end
    end
  endtask

  task automatic test_hold_start();
    build_ref(K1, 0);
    build_ref(K1, 11);
    run_sched(K1, K1, 1, 24);
    checks++; if (nwr !== 22) begin errors++; $display("FAIL hold_nwr: got %0d expected 22", nwr); end
    checks++; if (ndone !== 2) begin errors++; $display("FAIL hold_ndone: got %0d expected 2", ndone); end
    checks++; if (done_edge[0] !== 12) begin errors++; $display("FAIL hold_done0: got %0d expected 12", done_edge[0]); end
    checks++; if (done_edge[1] !== 24) begin errors++; $display("FAIL hold_done1: got %0d expected 24", done_edge[1]); end
    for (int i = 0; i < 22; i++) begin
      checks++; if (wr_addr[i] !== 4'(i % 11)) begin errors++; $display("FAIL hold_addr[%0d]: got %0d expected %0d", i, wr_addr[i], i % 11); end
      checks++; if (wr_edge[i] !== (i < 11 ? i + 1 : i + 2)) begin errors++; $display("FAIL hold_edge[%0d]: got %0d expected %0d", i, wr_edge[i], (i < 11 ? i + 1 : i + 2)); end
      checks++; if (wr_data[i] !== ref_rk[i]) begin errors++; $display("FAIL hold_rk[%0d]: got %h expected %h", i, wr_data[i], ref_rk[i]); end
    end
  endtask

  task automatic test_async_reset();
    int late_we;
    int late_done;
    bus.key_in = K1;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
    end
    checks++; if (bus.mem_addr !== 4'd5) begin errors++; $display("FAIL arst_pre_addr: got %0d expected 5", bus.mem_addr); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL arst_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.mem_addr !== 4'd0) begin errors++; $display("FAIL arst_addr: got %0d expected 0", bus.mem_addr); end
    #2;
    rst = 1'b0;
    late_we   = 0;
    late_done = 0;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      #1;
      if (bus.mem_we === 1'b1) late_we++;
      if (bus.done === 1'b1) late_done++;
    end
    checks++; if (late_done !== 0) begin errors++; $display("FAIL arst_no_done: got %0d expected 0", late_done); end
    checks++; if (late_we !== 0) begin errors++; $display("FAIL arst_no_we: got %0d expected 0", late_we); end
  endtask

  task automatic test_back_to_back();
    build_ref(K1, 0);
    build_ref(K3, 11);
    run_sched(K1, K3, 3, 26);
    checks++; if (nwr !== 22) begin errors++; $display("FAIL b2b_nwr: got %0d expected 22", nwr); end
    checks++; if (ndone !== 2) begin errors++; $display("FAIL b2b_ndone: got %0d expected 2", ndone); end
    checks++; if (done_edge[1] !== 24) begin errors++; $display("FAIL b2b_done1: got %0d expected 24", done_edge[1]); end
    for (int i = 0; i < 22; i++) begin
      checks++; if (wr_addr[i] !== 4'(i % 11)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", i, wr_addr[i], i % 11); end
      checks++; if (wr_data[i] !== ref_rk[i]) begin errors++; $display("FAIL b2b_rk[%0d]: got %h expected %h", i, wr_data[i], ref_rk[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_known_key();
    test_zero_key();
    test_key_change();
    test_hold_start();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
